// File: rtl/cast_credit_injector.sv
// Credit-gated injection stage in front of a PE cast-network receive FIFO.
// Flits pass through a one-flit output register; HEADs may require a whole packet of credits.
module cast_credit_injector #(
  parameter int DW         = 16,
  parameter int CREDITS    = 8,
  parameter int CRD_W      = 4,
  parameter int PKT_LEN    = 4,
  parameter int PKT_ATOMIC = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic [DW-1:0]    data_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [DW-1:0]    data_o,
  input  logic             ready_i,
  input  logic             credit_upd_i,
  output logic [CRD_W-1:0] credit_cnt_o,
  output logic             err_o,
  output logic             state_o
);

  // Handshakes: a transfer happens on a clock edge where valid and ready are both
  // high; valid never depends on ready, and ready_o carries no path from credit_upd_i.

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  localparam logic [1:0] FT_HEAD = 2'b01;
  localparam logic [1:0] FT_BODY = 2'b10;
  localparam logic [1:0] FT_TAIL = 2'b11;

  localparam logic [CRD_W-1:0] CRD_MAX   = CRD_W'(CREDITS);
  localparam logic [CRD_W-1:0] HEAD_NEED = CRD_W'((PKT_ATOMIC != 0) ? PKT_LEN : 1);

  state_t           state_q, state_d;
  logic             valid_q, valid_d;
  logic [DW-1:0]    data_q, data_d;
  logic [CRD_W-1:0] crd_q, crd_d;
  logic             err_q, err_d;

  logic [1:0] ftype;
  logic       is_head, is_bt, slot_free, load, drop;

  always_comb begin
    ftype     = data_i[DW-1:DW-2];
    is_head   = (ftype == FT_HEAD);
    is_bt     = (ftype == FT_BODY) || (ftype == FT_TAIL);
    slot_free = ~valid_q | ready_i;
    load      = 1'b0;
    drop      = 1'b0;

    // Out-of-order flit types are swallowed (accepted, never forwarded) and flagged.
    if (valid_i && !rst) begin
      case (state_q)
        IDLE: begin
          if (is_head) load = slot_free && (crd_q >= HEAD_NEED);
          else         drop = 1'b1;
        end
        SEND: begin
          if (is_bt) load = slot_free && (crd_q != '0);
          else       drop = 1'b1;
        end
        default: drop = 1'b0;
      endcase
    end
    ready_o = load | drop;

    state_d = state_q;
    if (load && (state_q == IDLE))                     state_d = SEND;
    else if (load && (state_q == SEND) && (ftype == FT_TAIL)) state_d = IDLE;

    valid_d = slot_free ? load : valid_q;
    data_d  = load ? data_i : data_q;

    // Credits are reserved at load time, so the count gates loads directly.
    crd_d = crd_q;
    err_d = err_q | drop;
    case ({load, credit_upd_i})
      2'b10: crd_d = crd_q - CRD_W'(1);
      2'b01: begin
        if (crd_q == CRD_MAX) err_d = 1'b1;
        else                  crd_d = crd_q + CRD_W'(1);
      end
      default: crd_d = crd_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      data_q  <= '0;
      crd_q   <= CRD_MAX;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      crd_q   <= crd_d;
      err_q   <= err_d;
    end
  end

  assign valid_o      = valid_q;
  assign data_o       = data_q;
  assign credit_cnt_o = crd_q;
  assign err_o        = err_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_cast_credit_injector.sv
// Directed bench: instance a is packet-atomic, instance b is non-atomic; CREDITS=8, PKT_LEN=4.
module tb_cast_credit_injector;

  localparam logic [1:0] HD = 2'b01;
  localparam logic [1:0] BD = 2'b10;
  localparam logic [1:0] TL = 2'b11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst, a_valid_i, a_ready_i, a_upd, a_ready_o, a_valid_o, a_err_o, a_st;
  logic [15:0] a_data_i, a_data_o;
  logic [3:0]  a_cnt_o;
  logic        b_rst, b_valid_i, b_ready_i, b_upd, b_ready_o, b_valid_o, b_err_o, b_st;
  logic [15:0] b_data_i, b_data_o;
  logic [3:0]  b_cnt_o;

  cast_credit_injector #(.DW(16), .CREDITS(8), .CRD_W(4), .PKT_LEN(4), .PKT_ATOMIC(1)) dut_a (
    .clk(clk), .rst(a_rst), .valid_i(a_valid_i), .data_i(a_data_i), .ready_o(a_ready_o),
    .valid_o(a_valid_o), .data_o(a_data_o), .ready_i(a_ready_i), .credit_upd_i(a_upd),
    .credit_cnt_o(a_cnt_o), .err_o(a_err_o), .state_o(a_st));

  cast_credit_injector #(.DW(16), .CREDITS(8), .CRD_W(4), .PKT_LEN(4), .PKT_ATOMIC(0)) dut_b (
    .clk(clk), .rst(b_rst), .valid_i(b_valid_i), .data_i(b_data_i), .ready_o(b_ready_o),
    .valid_o(b_valid_o), .data_o(b_data_o), .ready_i(b_ready_i), .credit_upd_i(b_upd),
    .credit_cnt_o(b_cnt_o), .err_o(b_err_o), .state_o(b_st));

  // Snapshot layout: {valid_o, data_o, credit_cnt_o, err_o, state}
  logic [22:0] a_snap, b_snap, exp;
  assign a_snap = {a_valid_o, a_data_o, a_cnt_o, a_err_o, a_st};
  assign b_snap = {b_valid_o, b_data_o, b_cnt_o, b_err_o, b_st};

  int vec_cnt = 0;
  int mis_cnt = 0;
  logic [1:0] pt [4] = '{HD, BD, BD, TL};

  function automatic logic [15:0] mk(input logic [1:0] t, input int p);
    return {t, 14'(p)};
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic a_set(input logic v, input logic [15:0] d, input logic r, input logic u);
    a_valid_i = v; a_data_i = d; a_ready_i = r; a_upd = u; #1;
  endtask

  task automatic b_set(input logic v, input logic [15:0] d, input logic r, input logic u);
    b_valid_i = v; b_data_i = d; b_ready_i = r; b_upd = u; #1;
  endtask

  task automatic test_reset();
    a_rst = 1'b1; b_rst = 1'b1;
    a_set(1'b1, mk(HD, 0), 1'b1, 1'b0);
    b_set(1'b1, mk(HD, 0), 1'b1, 1'b0);
    tick(); tick();
    vec_cnt++; if (a_ready_o !== 1'b0) begin mis_cnt++; $display("FAIL rst_ready: got %b exp 0", a_ready_o); end
    exp = {1'b0, 16'h0, 4'd8, 1'b0, 1'b0};
    vec_cnt++; if (a_snap !== exp) begin mis_cnt++; $display("FAIL rst_a: got %h exp %h", a_snap, exp); end
    vec_cnt++; if (b_snap !== exp) begin mis_cnt++; $display("FAIL rst_b: got %h exp %h", b_snap, exp); end
    a_set(1'b0, 16'h0, 1'b1, 1'b0);
    b_set(1'b0, 16'h0, 1'b1, 1'b0);
    a_rst = 1'b0; b_rst = 1'b0;
    tick();
  endtask

  task automatic test_packet();
    for (int i = 0; i < 4; i++) begin
      a_set(1'b1, mk(pt[i], i), 1'b1, 1'b0);
      vec_cnt++; if (a_ready_o !== 1'b1) begin mis_cnt++; $display("FAIL pkt_ready[%0d]: got %b exp 1", i, a_ready_o); end
      tick();
      exp = {1'b1, mk(pt[i], i), 4'(7 - i), 1'b0, (i == 3) ? 1'b0 : 1'b1};
      vec_cnt++; if (a_snap !== exp) begin mis_cnt++; $display("FAIL pkt[%0d]: got %h exp %h", i, a_snap, exp); end
    end
  endtask

  task automatic test_credit_exhaust();
    for (int i = 0; i < 4; i++) begin
      a_set(1'b1, mk(pt[i], 16 + i), 1'b1, 1'b0);
      tick();
      exp = {1'b1, mk(pt[i], 16 + i), 4'(3 - i), 1'b0, (i == 3) ? 1'b0 : 1'b1};
      vec_cnt++; if (a_snap !== exp) begin mis_cnt++; $display("FAIL exh_pkt[%0d]: got %h exp %h", i, a_snap, exp); end
    end
    a_set(1'b1, mk(HD, 32), 1'b1, 1'b0);
    vec_cnt++; if (a_ready_o !== 1'b0) begin mis_cnt++; $display("FAIL exh_stall0: got %b exp 0", a_ready_o); end
    tick();
    exp = {1'b0, mk(TL, 19), 4'd0, 1'b0, 1'b0};
    vec_cnt++; if (a_snap !== exp) begin mis_cnt++; $display("FAIL exh_drain: got %h exp %h", a_snap, exp); end
    for (int k = 0; k < 4; k++) begin
      a_set(1'b1, mk(HD, 32), 1'b1, 1'b1);
      vec_cnt++; if (a_ready_o !== 1'b0) begin mis_cnt++; $display("FAIL exh_stall[%0d]: got %b exp 0", k, a_ready_o); end
      tick();
      vec_cnt++; if (a_cnt_o !== 4'(k + 1)) begin mis_cnt++; $display("FAIL exh_cnt[%0d]: got %0d exp %0d", k, a_cnt_o, k + 1); end
    end
    a_set(1'b1, mk(HD, 32), 1'b1, 1'b0);
    vec_cnt++; if (a_ready_o !== 1'b1) begin mis_cnt++; $display("FAIL exh_admit: got %b exp 1", a_ready_o); end
    tick();
    exp = {1'b1, mk(HD, 32), 4'd3, 1'b0, 1'b1};
    vec_cnt++; if (a_snap !== exp) begin mis_cnt++; $display("FAIL exh_head: got %h exp %h", a_snap, exp); end
    for (int i = 1; i < 4; i++) begin
      a_set(1'b1, mk(pt[i], 32 + i), 1'b1, 1'b1);
      tick();
    end
    exp = {1'b1, mk(TL, 35), 4'd3, 1'b0, 1'b0};
    vec_cnt++; if (a_snap !== exp) begin mis_cnt++; $display("FAIL exh_load_upd: got %h exp %h", a_snap, exp); end
    a_set(1'b0, 16'h0, 1'b1, 1'b1);
    tick(); tick();
    exp = {1'b0, mk(TL, 35), 4'd5, 1'b0, 1'b0};
    vec_cnt++; if (a_snap !== exp) begin mis_cnt++; $display("FAIL exh_refill: got %h exp %h", a_snap, exp); end
  endtask

  task automatic test_same_cycle();
    a_set(1'b1, mk(HD, 40), 1'b1, 1'b1);
    vec_cnt++; if (a_ready_o !== 1'b1) begin mis_cnt++; $display("FAIL same_ready: got %b exp 1", a_ready_o); end
    tick();
    exp = {1'b1, mk(HD, 40), 4'd5, 1'b0, 1'b1};
    vec_cnt++; if (a_snap !== exp) begin mis_cnt++; $display("FAIL same_cnt: got %h exp %h", a_snap, exp); end
    for (int i = 1; i < 4; i++) begin
      a_set(1'b1, mk(pt[i], 40 + i), 1'b1, 1'b0);
      tick();
    end
    vec_cnt++; if (a_cnt_o !== 4'd2) begin mis_cnt++; $display("FAIL same_after: got %0d exp 2", a_cnt_o); end
    a_set(1'b0, 16'h0, 1'b1, 1'b1);
    for (int k = 0; k < 6; k++) tick();
    exp = {1'b0, mk(TL, 43), 4'd8, 1'b0, 1'b0};
    vec_cnt++; if (a_snap !== exp) begin mis_cnt++; $display("FAIL same_full: got %h exp %h", a_snap, exp); end
    tick();
    exp = {1'b0, mk(TL, 43), 4'd8, 1'b1, 1'b0};
    vec_cnt++; if (a_snap !== exp) begin mis_cnt++; $display("FAIL sat_err: got %h exp %h", a_snap, exp); end
    a_set(1'b0, 16'h0, 1'b1, 1'b0);
    tick();
    vec_cnt++; if (a_snap !== exp) begin mis_cnt++; $display("FAIL sat_sticky: got %h exp %h", a_snap, exp); end
  endtask

  task automatic test_backpressure();
    a_set(1'b1, mk(HD, 48), 1'b1, 1'b0);
    tick();
    exp = {1'b1, mk(HD, 48), 4'd7, 1'b1, 1'b1};
    a_set(1'b1, mk(BD, 49), 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      vec_cnt++; if (a_ready_o !== 1'b0) begin mis_cnt++; $display("FAIL bp_ready[%0d]: got %b exp 0", k, a_ready_o); end
      tick();
      vec_cnt++; if (a_snap !== exp) begin mis_cnt++; $display("FAIL bp_hold[%0d]: got %h exp %h", k, a_snap, exp); end
    end
    a_set(1'b1, mk(BD, 49), 1'b1, 1'b0);
    vec_cnt++; if (a_ready_o !== 1'b1) begin mis_cnt++; $display("FAIL bp_release: got %b exp 1", a_ready_o); end
    tick();
    exp = {1'b1, mk(BD, 49), 4'd6, 1'b1, 1'b1};
    vec_cnt++; if (a_snap !== exp) begin mis_cnt++; $display("FAIL bp_next: got %h exp %h", a_snap, exp); end
    for (int i = 2; i < 4; i++) begin
      a_set(1'b1, mk(pt[i], 48 + i), 1'b1, 1'b0);
      tick();
    end
    a_set(1'b0, 16'h0, 1'b1, 1'b0);
    tick();
    exp = {1'b0, mk(TL, 51), 4'd4, 1'b1, 1'b0};
    vec_cnt++; if (a_snap !== exp) begin mis_cnt++; $display("FAIL bp_done: got %h exp %h", a_snap, exp); end
  endtask

  task automatic test_headless();
    a_rst = 1'b1; tick(); a_rst = 1'b0;
    a_set(1'b1, mk(BD, 56), 1'b1, 1'b0);
    vec_cnt++; if (a_ready_o !== 1'b1) begin mis_cnt++; $display("FAIL hl_ready: got %b exp 1", a_ready_o); end
    tick();
    exp = {1'b0, 16'h0, 4'd8, 1'b1, 1'b0};
    vec_cnt++; if (a_snap !== exp) begin mis_cnt++; $display("FAIL hl_drop: got %h exp %h", a_snap, exp); end
    a_set(1'b1, mk(HD, 57), 1'b1, 1'b0);
    tick();
    a_set(1'b1, mk(HD, 58), 1'b1, 1'b0);
    vec_cnt++; if (a_ready_o !== 1'b1) begin mis_cnt++; $display("FAIL hh_ready: got %b exp 1", a_ready_o); end
    tick();
    exp = {1'b0, mk(HD, 57), 4'd7, 1'b1, 1'b1};
    vec_cnt++; if (a_snap !== exp) begin mis_cnt++; $display("FAIL hh_drop: got %h exp %h", a_snap, exp); end
  endtask

  task automatic test_reset_mid();
    a_set(1'b1, mk(BD, 59), 1'b1, 1'b0);
    tick();
    a_rst = 1'b1;
    a_set(1'b1, mk(BD, 60), 1'b1, 1'b1);
    vec_cnt++; if (a_ready_o !== 1'b0) begin mis_cnt++; $display("FAIL rmid_ready: got %b exp 0", a_ready_o); end
    tick();
    exp = {1'b0, 16'h0, 4'd8, 1'b0, 1'b0};
    vec_cnt++; if (a_snap !== exp) begin mis_cnt++; $display("FAIL rmid: got %h exp %h", a_snap, exp); end
    a_rst = 1'b0;
    a_set(1'b0, 16'h0, 1'b1, 1'b0);
    tick();
  endtask

  task automatic test_non_atomic();
    for (int i = 0; i < 4; i++) begin
      b_set(1'b1, mk(pt[i], 64 + i), 1'b1, 1'b0);
      tick();
    end
    b_set(1'b1, mk(HD, 68), 1'b1, 1'b0); tick();
    b_set(1'b1, mk(TL, 69), 1'b1, 1'b0); tick();
    exp = {1'b1, mk(TL, 69), 4'd2, 1'b0, 1'b0};
    vec_cnt++; if (b_snap !== exp) begin mis_cnt++; $display("FAIL na_setup: got %h exp %h", b_snap, exp); end
    b_set(1'b1, mk(HD, 70), 1'b1, 1'b0);
    vec_cnt++; if (b_ready_o !== 1'b1) begin mis_cnt++; $display("FAIL na_head: got %b exp 1", b_ready_o); end
    tick();
    b_set(1'b1, mk(BD, 71), 1'b1, 1'b0); tick();
    exp = {1'b1, mk(BD, 71), 4'd0, 1'b0, 1'b1};
    vec_cnt++; if (b_snap !== exp) begin mis_cnt++; $display("FAIL na_body1: got %h exp %h", b_snap, exp); end
    b_set(1'b1, mk(BD, 72), 1'b1, 1'b0);
    vec_cnt++; if (b_ready_o !== 1'b0) begin mis_cnt++; $display("FAIL na_stall: got %b exp 0", b_ready_o); end
    tick();
    exp = {1'b0, mk(BD, 71), 4'd0, 1'b0, 1'b1};
    vec_cnt++; if (b_snap !== exp) begin mis_cnt++; $display("FAIL na_bubble: got %h exp %h", b_snap, exp); end
    b_set(1'b1, mk(BD, 72), 1'b1, 1'b1);
    vec_cnt++; if (b_ready_o !== 1'b0) begin mis_cnt++; $display("FAIL na_upd_comb: got %b exp 0", b_ready_o); end
    tick();
    b_set(1'b1, mk(BD, 72), 1'b1, 1'b0);
    vec_cnt++; if (b_ready_o !== 1'b1) begin mis_cnt++; $display("FAIL na_resume: got %b exp 1", b_ready_o); end
    tick();
    b_set(1'b1, mk(TL, 73), 1'b1, 1'b0);
    vec_cnt++; if (b_ready_o !== 1'b0) begin mis_cnt++; $display("FAIL na_tail_wait: got %b exp 0", b_ready_o); end
    tick();
    b_set(1'b1, mk(TL, 73), 1'b1, 1'b1); tick();
    b_set(1'b1, mk(TL, 73), 1'b1, 1'b0);
    vec_cnt++; if (b_ready_o !== 1'b1) begin mis_cnt++; $display("FAIL na_tail_go: got %b exp 1", b_ready_o); end
    tick();
    exp = {1'b1, mk(TL, 73), 4'd0, 1'b0, 1'b0};
    vec_cnt++; if (b_snap !== exp) begin mis_cnt++; $display("FAIL na_tail: got %h exp %h", b_snap, exp); end
    b_set(1'b0, 16'h0, 1'b1, 1'b0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    a_rst = 1'b1; b_rst = 1'b1;
    a_valid_i = 1'b0; a_data_i = '0; a_ready_i = 1'b1; a_upd = 1'b0;
    b_valid_i = 1'b0; b_data_i = '0; b_ready_i = 1'b1; b_upd = 1'b0;
    test_reset();
    test_packet();
    test_credit_exhaust();
    test_same_cycle();
    test_backpressure();
    test_headless();
    test_reset_mid();
    test_non_atomic();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
    $finish;
  end

endmodule

// File: doc/cast_credit_injector.md
Name: cast_credit_injector

Overview:
- Injection stage directly upstream of a PE's cast-network input port, i.e. the receive FIFO of depth `BUFFER_ALLOC.
- Accepts cast flits from a local source (router output or traffic generator) and forwards them through a one-flit output register.
- Forwards a flit only while it holds a credit for the downstream receive FIFO; the downstream credit-update pulse (one per flit drained) returns credits.
- Optional packet-atomic mode: a HEAD flit is admitted only when credits cover a whole packet, so a packet is never split across a credit stall.

Parameters:
- CREDITS, `BUFFER_ALLOC: initial and maximum credits; equals the downstream receive FIFO depth.
- CRD_W, `BUFFER_ALLOC_LOG+1: credit counter width; must hold the value CREDITS.
- PKT_LEN, `PKT_LEN: flits per packet, HEAD and TAIL included.
- PKT_ATOMIC, 1: 1 = HEAD admitted only if credits >= PKT_LEN; 0 = HEAD needs 1 credit.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- valid_i  input  1  source flit valid.
- data_i  input  `DW  source flit; [`DW-1:`DW-2] is the flit type (`HEAD/`BODY/`TAIL).
- ready_o  output  1  flit accepted this cycle.
- valid_o  output  1  flit valid toward the PE cast input.
- data_o  output  `DW  flit toward the PE cast input.
- ready_i  input  1  PE cast input ready.
- credit_upd_i  input  1  one-cycle pulse per flit read from the downstream FIFO; returns one credit.
- credit_cnt_o  output  CRD_W  current credit count.
- err_o  output  1  sticky protocol/credit error flag.

Behaviour:
- Reset (rst=1 at a clk edge): valid_o=0, data_o=0, credit_cnt_o=CREDITS, err_o=0, FSM=IDLE, ready_o=0 (combinational, follows from the state). Reset mid-packet discards the flit in flight; no credit restore beyond CREDITS.
- Output register slot is free when ~valid_o | ready_i.
- FSM IDLE:
  - Input is HEAD and slot free and credit_cnt_o >= (PKT_ATOMIC ? PKT_LEN : 1): ready_o=1; load the flit; go to SEND.
  - If a HEAD+TAIL single-flit packet is supported later, it is out of scope; PKT_LEN must be >= 2.
  - Input is BODY/TAIL (headless): ready_o=1, flit dropped, err_o set, stay IDLE.
- FSM SEND: BODY/TAIL accepted when slot free and credit_cnt_o >= 1. Accepted TAIL -> IDLE. HEAD in SEND: ready_o=1, flit dropped, err_o set, stay in SEND.
- Load: data_o <= data_i, valid_o <= 1. With a free slot and no load, valid_o <= 0. With ready_i=0 and valid_o=1, data_o and valid_o hold.
- Latency: one cycle from input handshake to valid_o; full throughput of 1 flit/cycle while credits > 0 and ready_i=1.
- Credits: decremented when a flit is loaded into the output register (slot reserved), not at the output handshake. Incremented by credit_upd_i. Load and credit_upd_i in the same cycle leave the count unchanged.
- credit_upd_i arriving with credit_cnt_o==CREDITS and no load: count saturates at CREDITS; err_o set.
- Count never goes below 0 (loads are gated by the count).
- err_o is sticky until rst. Error flits never consume credits.
- ready_o is combinational from valid_i, data_i type, FSM state, valid_o, ready_i and credit_cnt_o. No combinational path from credit_upd_i to ready_o.
- In atomic mode a packet admitted in IDLE never stalls on credits mid-packet. It can still stall on ready_i.

Test Plan:
- CREDITS=8, PKT_LEN=4, atomic. Send H,B,B,T back-to-back with ready_i=1 and no credit_upd -> valid_o high for cycles 1-4 after the first handshake; credit_cnt_o 8->4; FSM returns to IDLE.
- Two more packets, no credit_upd -> the second packet passes and the count reaches 0. The third HEAD stalls (ready_o=0). One credit_upd_i pulse gives count 1 and HEAD still stalls; 4 pulses total -> HEAD accepted next cycle.
- PKT_ATOMIC=0, count=2, 4-flit packet -> H and B pass, 2nd B stalls mid-packet. Credit pulse -> it resumes; TAIL waits for the next pulse.
- Load and credit_upd_i in the same cycle at count=5 -> count stays 5. Credit pulse at count=8 with idle input -> count stays 8 and err_o=1 thereafter.
- ready_i=0 for 3 cycles with a flit in the output register -> data_o/valid_o stable, ready_o=0, count unchanged. ready_i=1 -> the next flit follows on the following cycle.
- BODY flit in IDLE -> ready_o=1, no valid_o, count unchanged, err_o=1. Assert rst mid-packet -> all outputs return to reset values next cycle.
